// File: rtl/config_pkg.sv
// Shared configuration for the radix-2 divider: quotient width and FSM state encoding.
package config_pkg;
    localparam int DIVb = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/fdivsqrtuotfc2.sv
// Radix-2 on-the-fly converter: folds one signed digit into the U / U-1ulp pair.
module fdivsqrtuotfc2
    import config_pkg::*;
#(
    parameter int DIVb = config_pkg::DIVb
) (
    input  logic            up,
    input  logic            un,
    input  logic [DIVb+1:0] C,
    input  logic [DIVb:0]   U,
    input  logic [DIVb:0]   UM,
    output logic [DIVb:0]   UNext,
    output logic [DIVb:0]   UMNext
);
    logic [DIVb:0] w_k;
    logic          w_unused_c_top;

    assign w_unused_c_top = C[DIVb+1];

    // C is a thermometer code; its lowest set bit marks the current digit position.
    assign w_k[0] = C[0];
    genvar gi;
    generate
        for (gi = 1; gi <= DIVb; gi++) begin : g_onehot
            assign w_k[gi] = C[gi] & ~C[gi-1];
        end
    endgenerate

    always_comb begin
        UNext  = U;
        UMNext = UM;
        if (up) begin
            UNext  = U | w_k;
            UMNext = U;
        end else if (un) begin
            UNext  = UM | w_k;
            UMNext = UM;
        end else begin
            UNext  = U;
            UMNext = UM | w_k;
        end
    end
endmodule

// File: rtl/fdivsqrt_r2_seq.sv
// Sequential radix-2 SRT divider: one quotient digit per cycle, DIVb+1 digits per operation.
module fdivsqrt_r2_seq
    import config_pkg::*;
#(
    parameter int DIVb = config_pkg::DIVb
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Start,
    input  logic          Flush,
    input  logic [DIVb:0] X,
    input  logic [DIVb:0] D,
    output logic          Busy,
    output logic          Done,
    output logic [DIVb:0] Q,
    output logic [DIVb:0] QM,
    output logic          RemNeg
);
    localparam int WW = DIVb + 4;
    localparam int CW = $clog2(DIVb + 1);

    state_t          r_state, w_state_next;
    logic [WW-1:0]   r_w, w_w2, w_d_ext, w_w_next;
    logic [DIVb:0]   r_d, r_u, r_um, w_u_next, w_um_next;
    logic [DIVb+1:0] r_c;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      w_e;
    logic            w_up, w_un, w_accept, w_step;

    assign w_accept = (r_state == IDLE) && Start && !Flush;
    assign w_step   = (r_state == BUSY) && !Flush;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (Start) w_state_next = BUSY;
            BUSY:    if (r_cnt == '0) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (Flush) w_state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Residual: sign, 2 integer bits, DIVb+1 fraction bits; D is aligned to the same point.
    assign w_w2    = {r_w[WW-2:0], 1'b0};
    assign w_e     = w_w2[WW-1 -: 4];
    assign w_up    = $signed(w_e) >= 4'sd1;
    assign w_un    = $signed(w_e) < -4'sd1;
    assign w_d_ext = {2'b00, r_d, 1'b0};

    always_comb begin
        w_w_next = w_w2;
        if (w_up)      w_w_next = w_w2 - w_d_ext;
        else if (w_un) w_w_next = w_w2 + w_d_ext;
    end

    fdivsqrtuotfc2 #(.DIVb(DIVb)) u_otfc (
        .up     (w_up),
        .un     (w_un),
        .C      (r_c),
        .U      (r_u),
        .UM     (r_um),
        .UNext  (w_u_next),
        .UMNext (w_um_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d   <= '0;
            r_w   <= '0;
            r_u   <= '0;
            r_um  <= '0;
            r_c   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_d   <= D;
            r_w   <= {3'b000, X};
            r_u   <= '0;
            r_um  <= '0;
            r_c   <= {2'b11, {DIVb{1'b0}}};
            r_cnt <= CW'(DIVb);
        end else if (w_step) begin
            r_w  <= w_w_next;
            r_u  <= w_u_next;
            r_um <= w_um_next;
            r_c  <= {1'b1, r_c[DIVb+1:1]};
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
    end

    assign Busy   = (r_state == BUSY);
    assign Done   = (r_state == DONE);
    assign Q      = r_u;
    assign QM     = r_um;
    assign RemNeg = r_w[WW-1];
endmodule

// File: tb/tb_fdivsqrt_r2_seq.sv
// Bench for fdivsqrt_r2_seq: directed table, randomized operands against a floor-division model, and control corner cases.
module tb_fdivsqrt_r2_seq;
    import config_pkg::*;

    localparam int N   = config_pkg::DIVb;
    localparam int LAT = N + 2;

    typedef logic [N:0] mant_t;
    typedef struct {
        mant_t x;
        mant_t d;
        mant_t exp_sel;
        bit    exact;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset, Start, Flush;
    mant_t X, D, Q, QM;
    logic  Busy, Done, RemNeg;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fdivsqrt_r2_seq #(.DIVb(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Flush  (Flush),
        .X      (X),
        .D      (D),
        .Busy   (Busy),
        .Done   (Done),
        .Q      (Q),
        .QM     (QM),
        .RemNeg (RemNeg)
    );

    // Exact quotient X/D truncated to N fraction bits.
    function automatic mant_t ref_div(input mant_t x, input mant_t d);
        logic [63:0] num;
        num = 64'(x) << N;
        return mant_t'(num / 64'(d));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Starts an operation at a negedge; optionally pulses Start with other operands at BUSY cycle inj_at.
    task automatic run_op(input mant_t x, input mant_t d, input int inj_at, input mant_t x2, input mant_t d2,
                          output mant_t q, output mant_t qm, output logic rn, output int lat, output int busy_cnt);
        int n;
        Start = 1'b1; X = x; D = d;
        @(negedge clk);
        Start = 1'b0; X = mant_t'($urandom); D = mant_t'($urandom);
        n = 1; busy_cnt = 0; lat = -1;
        while (n <= 100) begin
            if (Done) begin
                lat = n;
                break;
            end
            if (Busy) busy_cnt++;
            if (n == inj_at) begin
                Start = 1'b1; X = x2; D = d2;
            end else begin
                Start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        Start = 1'b0;
        q = Q; qm = QM; rn = RemNeg;
    endtask

    task automatic check_op(input string tag, input mant_t x, input mant_t d, input mant_t q, input mant_t qm,
                            input logic rn, input int lat, input int bc);
        mant_t fl;
        fl = ref_div(x, d);
        $display("%s: x=%h d=%h q=%h qm=%h remneg=%b lat=%0d", tag, x, d, q, qm, rn, lat);
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " busy cycles"}, 64'(bc), 64'(N + 1));
        check({tag, " Q"}, 64'(q), rn ? 64'(fl + mant_t'(1)) : 64'(fl));
        check({tag, " QM"}, 64'(qm), rn ? 64'(fl) : 64'(fl - mant_t'(1)));
        // Outputs must hold after Done drops.
        @(negedge clk);
        check({tag, " done one-shot"}, 64'(Done), 64'(0));
        check({tag, " Q hold"}, 64'(Q), 64'(q));
    endtask

    initial begin
        vec_t  vecs [8];
        mant_t q, qm, x, d;
        logic  rn;
        int    lat, bc, done_seen;

        vecs[0] = '{x: 17'h10000, d: 17'h10000, exp_sel: 17'h10000, exact: 1'b1};
        vecs[1] = '{x: 17'h18000, d: 17'h10000, exp_sel: 17'h18000, exact: 1'b1};
        vecs[2] = '{x: 17'h10000, d: 17'h18000, exp_sel: 17'h0AAAA, exact: 1'b0};
        vecs[3] = '{x: 17'h1FFFF, d: 17'h10000, exp_sel: 17'h1FFFF, exact: 1'b1};
        vecs[4] = '{x: 17'h1FFFF, d: 17'h1FFFF, exp_sel: 17'h10000, exact: 1'b1};
        vecs[5] = '{x: 17'h10000, d: 17'h1FFFF, exp_sel: 17'h08000, exact: 1'b0};
        vecs[6] = '{x: 17'h1C000, d: 17'h1C000, exp_sel: 17'h10000, exact: 1'b1};
        vecs[7] = '{x: 17'h10000, d: 17'h14000, exp_sel: 17'h0CCCC, exact: 1'b0};

        reset = 1'b1; Start = 1'b0; Flush = 1'b0; X = '0; D = '0;
        repeat (3) @(negedge clk);
        check("reset Busy", 64'(Busy), 64'(0));
        check("reset Done", 64'(Done), 64'(0));
        check("reset Q", 64'(Q), 64'(0));
        check("reset QM", 64'(QM), 64'(0));
        check("reset RemNeg", 64'(RemNeg), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].x, vecs[i].d, 0, '0, '0, q, qm, rn, lat, bc);
            check_op($sformatf("table%0d", i), vecs[i].x, vecs[i].d, q, qm, rn, lat, bc);
            check($sformatf("table%0d selected", i), 64'(rn ? qm : q), 64'(vecs[i].exp_sel));
            if (vecs[i].exact) begin
                check($sformatf("table%0d exact Q", i), 64'(q), 64'(vecs[i].exp_sel));
                check($sformatf("table%0d exact RemNeg", i), 64'(rn), 64'(0));
            end
        end

        for (int i = 0; i < 40; i++) begin
            x = mant_t'($urandom); x[N] = 1'b1;
            d = mant_t'($urandom); d[N] = 1'b1;
            run_op(x, d, 0, '0, '0, q, qm, rn, lat, bc);
            check_op($sformatf("rand%0d", i), x, d, q, qm, rn, lat, bc);
        end

        // Start pulsed mid-iteration and on the last digit must not disturb the running divide.
        run_op(17'h10000, 17'h18000, 5, 17'h1FFFF, 17'h10000, q, qm, rn, lat, bc);
        check_op("start-in-busy", 17'h10000, 17'h18000, q, qm, rn, lat, bc);
        run_op(17'h18000, 17'h1C000, N + 1, 17'h10000, 17'h1FFFF, q, qm, rn, lat, bc);
        check_op("start-last-digit", 17'h18000, 17'h1C000, q, qm, rn, lat, bc);

        // Flush beats Start in IDLE.
        Start = 1'b1; Flush = 1'b1; X = 17'h10000; D = 17'h10000;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        check("flush-over-start Busy", 64'(Busy), 64'(0));
        @(negedge clk);

        // Flush at BUSY cycle 10, then a new Start on the very next cycle.
        begin
            mant_t qb, qmb;
            Start = 1'b1; X = 17'h10000; D = 17'h18000;
            @(negedge clk);
            Start = 1'b0;
            for (int k = 1; k < 10; k++) @(negedge clk);
            check("flush pre Busy", 64'(Busy), 64'(1));
            qb = Q; qmb = QM;
            Flush = 1'b1;
            @(negedge clk);
            Flush = 1'b0;
            check("flush Busy", 64'(Busy), 64'(0));
            check("flush Done", 64'(Done), 64'(0));
            check("flush Q held", 64'(Q), 64'(qb));
            check("flush QM held", 64'(QM), 64'(qmb));
            run_op(17'h18000, 17'h10000, 0, '0, '0, q, qm, rn, lat, bc);
            check_op("after-flush", 17'h18000, 17'h10000, q, qm, rn, lat, bc);
        end

        // Reset in the middle of an operation.
        Start = 1'b1; X = 17'h1FFFF; D = 17'h14000;
        @(negedge clk);
        Start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset Busy", 64'(Busy), 64'(0));
        check("midreset Done", 64'(Done), 64'(0));
        check("midreset Q", 64'(Q), 64'(0));
        check("midreset QM", 64'(QM), 64'(0));
        check("midreset RemNeg", 64'(RemNeg), 64'(0));
        done_seen = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (Done || Busy) done_seen++;
        end
        check("midreset stays idle", 64'(done_seen), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
